cond_logic_cu: RTL and testbench
================================

// Module: cond_logic_cu
// PURPOSE
//  Condition stage directly downstream of the control-unit decoder. Holds the architectural
//  NZCV flags register, evaluates the instruction's 4-bit condition field against it, and
//  gates the decoder's pc_src / reg_write / mem_write / flag_write before they reach the
//  datapath. This is the only state in the control unit.
// PARAMETERS
//  FLAG_RESET    4'b0000  NZCV value loaded on reset (bit3=N, bit2=Z, bit1=C, bit0=V)
//  NV_EXECUTES   1'b0     1: cond 4'b1111 executes like AL; 0: cond 4'b1111 never executes
// PORTS
//  clk          in   1  rising-edge clock, single domain
//  rst_n        in   1  asynchronous, active-low reset
//  en           in   1  1 = instruction commits this cycle; 0 = stall
//  cond         in   4  instruction condition field, instr[31:28]
//  alu_flags    in   4  NZCV produced by the ALU this cycle
//  flag_write   in   2  from decoder: [1] updates N,Z; [0] updates C,V
//  pc_src       in   1  from decoder
//  reg_write    in   1  from decoder
//  mem_write    in   1  from decoder
//  no_write     in   1  from decoder: compare/test op, suppresses register write
//  pc_write     out  1  gated pc_src
//  reg_write_en out  1  gated reg_write
//  mem_write_en out  1  gated mem_write
//  cond_ex      out  1  condition passed (combinational)
//  flags        out  4  current registered NZCV
// BEHAVIOUR
//  - Reset: rst_n low asynchronously forces flags = FLAG_RESET. Outputs are combinational,
//    so with FLAG_RESET=0 and cond=EQ during reset: cond_ex=0 and all enables 0. Reset
//    asserted mid-instruction discards any pending flag update; no partial update.
//  - cond_ex is evaluated from the REGISTERED flags, never from alu_flags, so an
//    instruction's own flag result cannot affect its own condition.
//  - Condition table (N,Z,C,V = flags):
//    0000 EQ Z | 0001 NE ~Z | 0010 CS C | 0011 CC ~C | 0100 MI N | 0101 PL ~N
//    0110 VS V | 0111 VC ~V | 1000 HI C&~Z | 1001 LS ~C|Z | 1010 GE N==V | 1011 LT N!=V
//    1100 GT ~Z&(N==V) | 1101 LE Z|(N!=V) | 1110 AL 1 | 1111 NV_EXECUTES
//  - Gating, zero latency: pc_write = en&cond_ex&pc_src; mem_write_en = en&cond_ex&mem_write;
//    reg_write_en = en&cond_ex&reg_write&~no_write.
//  - Flag update at the rising clk edge, only when en&cond_ex:
//    flag_write[1] -> flags[3:2] <= alu_flags[3:2]; flag_write[0] -> flags[1:0] <= alu_flags[1:0].
//    The halves update independently; with flag_write=2'b10 the C,V bits hold.
//  - en=0: all write enables 0 and flags hold, regardless of cond or flag_write.
//  - Failed condition: the instruction becomes a NOP for writes and flags; no side effects.
//  - Back-to-back flag-setting instructions: instruction k+1 sees the flags written at the
//    end of cycle k (one-cycle flag latency). No forwarding from alu_flags.
// TESTING
//  1. Reset: rst_n=0 with FLAG_RESET=0 -> flags=0000; cond=NE -> cond_ex=1; cond=EQ -> cond_ex=0.
//  2. CMP then BEQ: cycle0 cond=AL, flag_write=11, alu_flags=0110, no_write=1, reg_write=1
//     -> reg_write_en=0; cycle1 cond=EQ, pc_src=1 -> pc_write=1, flags=0110.
//  3. Partial update: flags=1111; cond=AL, flag_write=10, alu_flags=0000 -> flags=0011 next cycle.
//  4. Failed condition: flags=0000; cond=EQ, reg_write=1, mem_write=1, flag_write=11,
//     alu_flags=1111 -> all enables 0, flags stay 0000.
//  5. Signed conditions: flags N=1,V=0 -> GE=0, LT=1, GT=0, LE=1; N=V=1,Z=0 -> GT=1.
//     Sweep all 16 cond codes x 16 flag values against the table, both NV_EXECUTES values.
//  6. Stall and async reset: en=0 with cond=AL, flag_write=11 -> enables 0, flags hold;
//     rst_n pulsed low between clock edges -> flags=FLAG_RESET immediately, before next edge.

Source files
------------

// File: rtl/cond_logic_cu.sv
// Condition stage behind the control-unit decoder: owns the NZCV flags register,
// evaluates the instruction condition field and gates the decoder's write strobes.
module cond_logic_cu #(
    parameter logic [3:0] FLAG_RESET  = 4'b0000,
    parameter logic       NV_EXECUTES = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_write,
    input  logic       pc_src,
    input  logic       reg_write,
    input  logic       mem_write,
    input  logic       no_write,
    output logic       pc_write,
    output logic       reg_write_en,
    output logic       mem_write_en,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic [3:0] flags_r;
    logic       cond_ex_s;
    logic       commit_s;

    // Condition table lookup; flag vector is {N, Z, C, V}.
    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f, input logic nv);
        logic n_s, z_s, c_s, v_s, res_s;
        n_s = f[3];
        z_s = f[2];
        c_s = f[1];
        v_s = f[0];
        case (c)
            4'b0000: res_s = z_s;
            4'b0001: res_s = ~z_s;
            4'b0010: res_s = c_s;
            4'b0011: res_s = ~c_s;
            4'b0100: res_s = n_s;
            4'b0101: res_s = ~n_s;
            4'b0110: res_s = v_s;
            4'b0111: res_s = ~v_s;
            4'b1000: res_s = c_s & ~z_s;
            4'b1001: res_s = ~c_s | z_s;
            4'b1010: res_s = (n_s == v_s);
            4'b1011: res_s = (n_s != v_s);
            4'b1100: res_s = ~z_s & (n_s == v_s);
            4'b1101: res_s = z_s | (n_s != v_s);
            4'b1110: res_s = 1'b1;
            4'b1111: res_s = nv;
            default: res_s = 1'b0;
        endcase
        return res_s;
    endfunction

    // Condition is judged against the registered flags only, never this cycle's ALU result.
    always_comb begin
        cond_ex_s = eval_cond(cond, flags_r, NV_EXECUTES);
        commit_s  = en & cond_ex_s;
    end

    assign cond_ex      = cond_ex_s;
    assign pc_write     = commit_s & pc_src;
    assign mem_write_en = commit_s & mem_write;
    assign reg_write_en = commit_s & reg_write & ~no_write;
    assign flags        = flags_r;

    // NZ and CV halves update independently, only for a committing instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= FLAG_RESET;
        end else if (commit_s) begin
            if (flag_write[1]) begin
                flags_r[3:2] <= alu_flags[3:2];
            end
            if (flag_write[0]) begin
                flags_r[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: tb/tb_cond_logic_cu.sv
// Directed, table-driven bench for cond_logic_cu; a second instance covers NV_EXECUTES=1.
module tb_cond_logic_cu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_write;
    logic       pc_src, reg_write, mem_write, no_write;

    logic       pc_write0, reg_write_en0, mem_write_en0, cond_ex0;
    logic [3:0] flags0;
    logic       pc_write1, reg_write_en1, mem_write_en1, cond_ex1;
    logic [3:0] flags1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cond_logic_cu #(.FLAG_RESET(4'b0000), .NV_EXECUTES(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .cond(cond), .alu_flags(alu_flags),
        .flag_write(flag_write), .pc_src(pc_src), .reg_write(reg_write),
        .mem_write(mem_write), .no_write(no_write), .pc_write(pc_write0),
        .reg_write_en(reg_write_en0), .mem_write_en(mem_write_en0),
        .cond_ex(cond_ex0), .flags(flags0)
    );

    cond_logic_cu #(.FLAG_RESET(4'b0000), .NV_EXECUTES(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .cond(cond), .alu_flags(alu_flags),
        .flag_write(flag_write), .pc_src(pc_src), .reg_write(reg_write),
        .mem_write(mem_write), .no_write(no_write), .pc_write(pc_write1),
        .reg_write_en(reg_write_en1), .mem_write_en(mem_write_en1),
        .cond_ex(cond_ex1), .flags(flags1)
    );

    typedef struct packed {
        logic       en;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       pc;
        logic       rw;
        logic       mw;
        logic       nw;
        logic       e_pc;
        logic       e_rw;
        logic       e_mw;
        logic       e_cx;
        logic [3:0] e_fl;
        logic       e_cx1;
        logic [3:0] e_fl1;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: even/odd code pairs share a base test, odd codes invert it.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f, input logic nv);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] != 3'd7) return base ^ c[0];
        return c[0] ? nv : 1'b1;
    endfunction

    task automatic drive(input logic e, input logic [3:0] c, input logic [3:0] a,
                         input logic [1:0] fw, input logic p, input logic r,
                         input logic m, input logic n);
        en = e; cond = c; alu_flags = a; flag_write = fw;
        pc_src = p; reg_write = r; mem_write = m; no_write = n;
    endtask

    initial begin
        // en cond alu fw pc rw mw nw | pc rw mw cx flags | cx1 flags1
        vecs[0]  = '{1'b1, 4'hE, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1, 4'b0110};
        vecs[1]  = '{1'b1, 4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1, 4'b0110};
        vecs[2]  = '{1'b1, 4'hE, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111};
        vecs[3]  = '{1'b1, 4'hE, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0011, 1'b1, 4'b0011};
        vecs[4]  = '{1'b1, 4'hE, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000};
        vecs[5]  = '{1'b1, 4'h0, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000};
        vecs[6]  = '{1'b0, 4'hE, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000};
        vecs[7]  = '{1'b1, 4'hE, 4'b1010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 4'b0010};
        vecs[8]  = '{1'b1, 4'hE, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 4'b1000};
        vecs[9]  = '{1'b1, 4'hA, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b1000};
        vecs[10] = '{1'b1, 4'hB, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b1, 4'b1000};
        vecs[11] = '{1'b1, 4'hC, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b1000};
        vecs[12] = '{1'b1, 4'hD, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 4'b1001};
        vecs[13] = '{1'b1, 4'hC, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 4'b1001};
        vecs[14] = '{1'b1, 4'hF, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b1, 4'b0000};

        // Reset state with the decoder strobes asserted.
        rst_n = 1'b0;
        drive(1'b1, 4'h1, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        check("reset_flags", flags0, 4'b0000);
        check("reset_flags_nv", flags1, 4'b0000);
        check("reset_ne_cx", {3'b000, cond_ex0}, 4'h1);
        cond = 4'h0;
        #1;
        check("reset_eq_cx", {3'b000, cond_ex0}, 4'h0);
        check("reset_enables", {1'b0, pc_write0, reg_write_en0, mem_write_en0}, 4'h0);
        @(posedge clk);
        #1;
        check("reset_hold_flags", flags0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].cond, vecs[i].alu, vecs[i].fw,
                  vecs[i].pc, vecs[i].rw, vecs[i].mw, vecs[i].nw);
            #1;
            check($sformatf("vec%0d_cx", i), {3'b000, cond_ex0}, {3'b000, vecs[i].e_cx});
            check($sformatf("vec%0d_cx_nv", i), {3'b000, cond_ex1}, {3'b000, vecs[i].e_cx1});
            check($sformatf("vec%0d_en", i), {1'b0, pc_write0, reg_write_en0, mem_write_en0},
                  {1'b0, vecs[i].e_pc, vecs[i].e_rw, vecs[i].e_mw});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_flags", i), flags0, vecs[i].e_fl);
            check($sformatf("vec%0d_flags_nv", i), flags1, vecs[i].e_fl1);
        end

        // Full condition sweep on both NV_EXECUTES settings.
        for (int f = 0; f < 16; f++) begin
            @(negedge clk);
            drive(1'b1, 4'hE, f[3:0], 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            en = 1'b0;
            check($sformatf("sweep_flags f=%h", f), flags0, f[3:0]);
            for (int c = 0; c < 16; c++) begin
                cond = c[3:0];
                #1;
                check($sformatf("sweep c=%h f=%h", c, f), {3'b000, cond_ex0},
                      {3'b000, ref_cond(c[3:0], f[3:0], 1'b0)});
                check($sformatf("sweep_nv c=%h f=%h", c, f), {3'b000, cond_ex1},
                      {3'b000, ref_cond(c[3:0], f[3:0], 1'b1)});
            end
        end

        // Async reset between edges, with a flag update pending.
        @(negedge clk);
        drive(1'b1, 4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_async_flags", flags0, 4'b1111);
        @(negedge clk);
        drive(1'b1, 4'hE, 4'b0101, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_flags", flags0, 4'b0000);
        check("async_reset_flags_nv", flags1, 4'b0000);
        @(posedge clk);
        #1;
        check("async_reset_discard", flags0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_update", flags0, 4'b0101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
